// File: rtl/coin_round_pkg.sv
// rtl/coin_round_pkg.sv - shared types, colour codes and golden table for coin_round_ctrl
package coin_round_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_C2,
    S_C1,
    S_C0,
    S_WAIT,
    S_RESP,
    S_GAP
  } state_t;

  localparam logic [1:0] C_00 = 2'b00;
  localparam logic [1:0] C_01 = 2'b01;
  localparam logic [1:0] C_10 = 2'b10;
  localparam logic [1:0] C_11 = 2'b11;

  localparam int RESULT_LAT_MIN = 1;
  localparam int RESULT_LAT_MAX = 15;
  localparam int GAP_CYC_MAX    = 15;
  localparam int CNT_W_MIN      = 1;

  function automatic logic [1:0] expected_color(input logic [2:0] pattern);
    case (pattern)
      3'b001:  return C_01;
      3'b011:  return C_10;
      3'b100:  return C_10;
      3'b110:  return C_01;
      default: return C_00;
    endcase
  endfunction

endpackage

// File: rtl/coin_round_tally.sv
// rtl/coin_round_tally.sv - three saturating per-colour counters; colour 11 is ignored
module coin_round_tally
  import coin_round_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic [1:0]       color,
  output logic [CNT_W-1:0] tally_00,
  output logic [CNT_W-1:0] tally_01,
  output logic [CNT_W-1:0] tally_10
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tally_00 <= '0;
      tally_01 <= '0;
      tally_10 <= '0;
    end else if (inc) begin
      case (color)
        C_00: if (tally_00 != CNT_MAX) tally_00 <= tally_00 + CNT_ONE;
        C_01: if (tally_01 != CNT_MAX) tally_01 <= tally_01 + CNT_ONE;
        C_10: if (tally_10 != CNT_MAX) tally_10 <= tally_10 + CNT_ONE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/coin_round_ctrl.sv
// rtl/coin_round_ctrl.sv - coin datapath round sequencer; COIN_ROUND_CHECK_EN adds golden-table checking
module coin_round_ctrl
  import coin_round_pkg::*;
#(
  parameter int RESULT_LAT = 1,
  parameter int GAP_CYC    = 2,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_pattern,
  output logic             coin_start,
  output logic             coin_bit,
  input  logic [1:0]       coin_color,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [1:0]       rsp_color,
  output logic [2:0]       rsp_pattern,
  output logic [CNT_W-1:0] tally_00,
  output logic [CNT_W-1:0] tally_01,
  output logic [CNT_W-1:0] tally_10,
  output logic             busy
`ifdef COIN_ROUND_CHECK_EN
  ,
  output logic             chk_err,
  output logic [CNT_W-1:0] err_cnt
`endif
);

  if (RESULT_LAT < RESULT_LAT_MIN || RESULT_LAT > RESULT_LAT_MAX ||
      GAP_CYC < 0 || GAP_CYC > GAP_CYC_MAX || CNT_W < CNT_W_MIN) begin : g_bad_param
    $error("coin_round_ctrl: parameter out of range");
  end

  localparam logic [3:0] WAIT_LAST = 4'(RESULT_LAT - 1);
  localparam logic [3:0] GAP_LAST  = 4'((GAP_CYC == 0) ? 0 : GAP_CYC - 1);

  state_t     state;
  logic [2:0] pattern_q;
  logic [3:0] cnt;
  logic       rsp_fire;

  assign rsp_pattern = pattern_q;
  assign busy        = (state != S_IDLE);
  assign rsp_fire    = rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      pattern_q  <= '0;
      cnt        <= '0;
      req_ready  <= 1'b1;
      coin_start <= 1'b0;
      coin_bit   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_color  <= C_00;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            pattern_q  <= req_pattern;
            req_ready  <= 1'b0;
            coin_start <= 1'b1;
            coin_bit   <= 1'b0;
            state      <= S_START;
          end
        end
        S_START: begin
          coin_start <= 1'b0;
          coin_bit   <= pattern_q[2];
          state      <= S_C2;
        end
        S_C2: begin
          coin_bit <= pattern_q[1];
          state    <= S_C1;
        end
        S_C1: begin
          coin_bit <= pattern_q[0];
          state    <= S_C0;
        end
        S_C0: begin
          coin_bit <= 1'b0;
          cnt      <= WAIT_LAST;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_color <= coin_color;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP: begin
          if (rsp_fire) begin
            rsp_valid <= 1'b0;
            if (GAP_CYC == 0) begin
              req_ready <= 1'b1;
              state     <= S_IDLE;
            end else begin
              cnt   <= GAP_LAST;
              state <= S_GAP;
            end
          end
        end
        S_GAP: begin
          if (cnt == 4'd0) begin
            req_ready <= 1'b1;
            state     <= S_IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  coin_round_tally #(.CNT_W(CNT_W)) u_tally (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (rsp_fire),
    .color    (rsp_color),
    .tally_00 (tally_00),
    .tally_01 (tally_01),
    .tally_10 (tally_10)
  );

`ifdef COIN_ROUND_CHECK_EN
  logic             mismatch;
  logic [CNT_W-1:0] unused_err_01;
  logic [CNT_W-1:0] unused_err_10;

  assign mismatch = rsp_fire && (rsp_color != expected_color(pattern_q));
  assign chk_err  = mismatch;

  // Only the 00 lane of this instance is used, as a plain saturating error counter.
  coin_round_tally #(.CNT_W(CNT_W)) u_err_tally (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (mismatch),
    .color    (C_00),
    .tally_00 (err_cnt),
    .tally_01 (unused_err_01),
    .tally_10 (unused_err_10)
  );
`endif

endmodule

// File: tb/tb_coin_round_ctrl.sv
// tb/tb_coin_round_ctrl.sv - scoreboard bench for coin_round_ctrl with a behavioural datapath model
module tb_coin_round_ctrl;

  localparam int RL   = 1;
  localparam int GAP  = 2;
  localparam int CW   = 3;
  localparam int TMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_pattern = 3'd0;
  logic          coin_start;
  logic          coin_bit;
  logic [1:0]    coin_color = 2'd0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [1:0]    rsp_color;
  logic [2:0]    rsp_pattern;
  logic [CW-1:0] tally_00, tally_01, tally_10;
  logic          busy;
`ifdef COIN_ROUND_CHECK_EN
  logic          chk_err;
  logic [CW-1:0] err_cnt;
`endif

  coin_round_ctrl #(.RESULT_LAT(RL), .GAP_CYC(GAP), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_pattern(req_pattern), .coin_start(coin_start), .coin_bit(coin_bit),
    .coin_color(coin_color), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_color(rsp_color), .rsp_pattern(rsp_pattern), .tally_00(tally_00),
    .tally_01(tally_01), .tally_10(tally_10), .busy(busy)
`ifdef COIN_ROUND_CHECK_EN
    , .chk_err(chk_err), .err_cnt(err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, got, want, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s timeout t=%0t", name, $time);
  endtask

  // Reference: colour the datapath should decide for each 3-bit pattern.
  logic [1:0] gold [0:7] = '{2'd0, 2'd1, 2'd0, 2'd2, 2'd2, 2'd0, 2'd1, 2'd0};

  typedef struct {
    logic [2:0] p;
    logic [1:0] c;
  } exp_t;
  exp_t exp_q[$];
  exp_t e;
  int   mt[4] = '{0, 0, 0, 0};
  int   merr = 0;

  logic       force11 = 1'b0;
  logic [2:0] cur_pat = 3'd0;
  int         rsp_mode = 0;

  always @(posedge clk) begin
    #2;
    case (rsp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = 1'b0;
    endcase
  end

  // Datapath model: deserialise the three coin cycles after a start pulse.
  int         nb = 3;
  logic [2:0] sh = 3'd0;
  always @(negedge clk) begin
    if (!rst_n) begin
      nb = 3;
    end else if (coin_start) begin
      nb = 0;
      sh = 3'd0;
    end else if (nb < 3) begin
      sh = {sh[1:0], coin_bit};
      nb++;
      if (nb == 3) begin
        chk("coin_bits", int'(sh), int'(cur_pat));
        coin_color = force11 ? 2'b11 : gold[sh];
      end
    end
  end

  logic       pv = 1'b0;
  logic [1:0] pc;
  logic [2:0] pp;
  bit         tpend = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      pv = 1'b0;
      tpend = 1'b0;
    end else begin
      if (tpend) begin
        chk("tally_00", int'(tally_00), mt[0]);
        chk("tally_01", int'(tally_01), mt[1]);
        chk("tally_10", int'(tally_10), mt[2]);
`ifdef COIN_ROUND_CHECK_EN
        chk("err_cnt", int'(err_cnt), merr);
`endif
        tpend = 1'b0;
      end
      if (pv) begin
        chk("hold_color", int'(rsp_color), int'(pc));
        chk("hold_pattern", int'(rsp_pattern), int'(pp));
      end
      pv = 1'b0;
      if (rsp_valid) begin
        chk("req_ready_in_resp", int'(req_ready), 0);
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            timeout_fail("spurious_rsp");
          end else begin
            e = exp_q.pop_front();
            chk("rsp_color", int'(rsp_color), int'(e.c));
            chk("rsp_pattern", int'(rsp_pattern), int'(e.p));
            if (e.c != 2'b11 && mt[e.c] < TMAX) mt[e.c]++;
            tpend = 1'b1;
`ifdef COIN_ROUND_CHECK_EN
            chk("chk_err_fire", int'(chk_err), int'(e.c != gold[e.p]));
            if (e.c != gold[e.p] && merr < TMAX) merr++;
`endif
          end
        end else begin
          pv = 1'b1;
          pc = rsp_color;
          pp = rsp_pattern;
        end
      end
`ifdef COIN_ROUND_CHECK_EN
      if (!(rsp_valid && rsp_ready)) chk("chk_err_quiet", int'(chk_err), 0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] p, input bit f11, input bit timing,
                      input bit wait_done, output int lowcnt);
    int t = 0;
    int c0;
    lowcnt = -1;
    while (!req_ready && t < 300) begin
      step();
      t++;
    end
    if (t >= 300) begin
      timeout_fail("req_ready_wait");
      return;
    end
    cur_pat = p;
    force11 = f11;
    req_valid = 1'b1;
    req_pattern = p;
    exp_q.push_back('{p: p, c: (f11 ? 2'b11 : gold[p])});
    step();
    req_valid = 1'b0;
    c0 = cyc;
    if (timing) begin
      chk("start_pulse", int'(coin_start), 1);
      chk("start_bit", int'(coin_bit), 0);
      chk("busy_start", int'(busy), 1);
      chk("req_ready_start", int'(req_ready), 0);
      for (int i = 2; i >= 0; i--) begin
        step();
        chk("bit_start_low", int'(coin_start), 0);
        chk("coin_bit_seq", int'(coin_bit), int'(p[i]));
      end
      for (int i = 0; i < RL; i++) begin
        step();
        chk("rsp_valid_wait", int'(rsp_valid), 0);
      end
      step();
      chk("rsp_valid_at_lat", int'(rsp_valid), 1);
    end
    if (!wait_done) return;
    t = 0;
    while (!req_ready && t < 300) begin
      step();
      t++;
    end
    if (t >= 300) timeout_fail("round_end");
    else lowcnt = cyc - c0;
  endtask

  int lc;
  int snap[3];

  initial begin
    rsp_mode = 0;
    step();
    step();
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_coin_start", int'(coin_start), 0);
    chk("rst_coin_bit", int'(coin_bit), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_tally", int'(tally_00) + int'(tally_01) + int'(tally_10), 0);
    rst_n = 1'b1;
    step();

    send(3'b011, 1'b0, 1'b1, 1'b1, lc);
    chk("req_ready_low", lc, 5 + RL + GAP);

    for (int p = 0; p < 8; p++) begin
      send(3'(p), 1'b0, 1'b1, 1'b1, lc);
      chk("req_ready_low", lc, 5 + RL + GAP);
    end
    step();
    chk("sweep_tally_00", int'(tally_00), 4);
    chk("sweep_tally_01", int'(tally_01), 2);
    chk("sweep_tally_10", int'(tally_10), 3);

    send(3'b000, 1'b1, 1'b0, 1'b1, lc);
    step();
    chk("c11_tally_00", int'(tally_00), 4);

    rsp_mode = 2;
    send(3'b110, 1'b0, 1'b0, 1'b0, lc);
    lc = 0;
    while (!rsp_valid && lc < 50) begin
      step();
      lc++;
    end
    if (lc >= 50) timeout_fail("rsp_valid_wait");
    snap = '{int'(tally_00), int'(tally_01), int'(tally_10)};
    for (int i = 0; i < 5; i++) begin
      step();
      chk("held_rsp_valid", int'(rsp_valid), 1);
      chk("held_req_ready", int'(req_ready), 0);
      chk("held_tally_01", int'(tally_01), snap[1]);
    end
    rsp_mode = 0;
    send(3'b001, 1'b0, 1'b0, 1'b1, lc);

    rsp_mode = 1;
    for (int i = 0; i < 45; i++)
      send(3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0), 1'b0, 1'b1, lc);
    rsp_mode = 0;
    step();
    step();
    chk("sat_tally_00", int'(tally_00), mt[0]);

    send(3'b111, 1'b0, 1'b0, 1'b0, lc);
    step();
    step();
    chk("c1_coin_bit", int'(coin_bit), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_coin_start", int'(coin_start), 0);
    chk("abort_coin_bit", int'(coin_bit), 0);
    chk("abort_req_ready", int'(req_ready), 1);
    exp_q.delete();
    mt = '{0, 0, 0, 0};
    merr = 0;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step();
      chk("abort_no_rsp", int'(rsp_valid), 0);
    end
    chk("abort_req_ready_after", int'(req_ready), 1);
    chk("abort_tally", int'(tally_00) + int'(tally_01) + int'(tally_10), 0);

    send(3'b100, 1'b0, 1'b1, 1'b1, lc);
    chk("req_ready_low_post", lc, 5 + RL + GAP);
    lc = 0;
    while (exp_q.size() != 0 && lc < 100) begin
      step();
      lc++;
    end
    if (lc >= 100) timeout_fail("drain");
    step();
    step();
    chk("final_tally_10", int'(tally_10), mt[2]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
